// File: rtl/key_cmd_decoder.sv
// ============================================================================
// Module      : key_cmd_decoder
// Description : PS/2 set-2 scan-code decoder producing one-cycle command pulses
//               with break/extended prefix handling, typematic suppression and
//               a prefix timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       help,
  output logic       menu,
  output logic       select_map,
  output logic       game_forest,
  output logic       game_castle,
  output logic [4:0] key_held,
  output logic       frame_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BRK     = 2'd1;
  localparam logic [1:0] S_EXT     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [7:0] BYTE_BRK = 8'hF0;
  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_ZERO = 8'h00;
  localparam logic [7:0] BYTE_ONES = 8'hFF;

  // Make codes packed in key_held bit order {C,F,ENTER,ESC,H}
  localparam logic [39:0] KEY_CODES = {8'h21, 8'h2B, 8'h5A, 8'h76, 8'h33};

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [4:0]       key_hit;
  logic [4:0]       pulse;
  logic [4:0]       pulse_nxt;
  logic [4:0]       held_nxt;
  logic             ferr_nxt;
  logic             err_byte;
  logic             byte_ok;
  logic             timeout;
  logic             is_brk;
  logic             is_ext;

  generate
    for (genvar i = 0; i < 5; i++) begin : g_key_match
      assign key_hit[i] = rx_valid && (rx_data == KEY_CODES[i*8 +: 8]);
    end
  endgenerate

  assign err_byte = rx_valid && ((rx_data == BYTE_ZERO) || (rx_data == BYTE_ONES));
  assign byte_ok  = rx_valid && !err_byte;
  assign is_brk   = rx_data == BYTE_BRK;
  assign is_ext   = rx_data == BYTE_EXT;
  // A byte arriving on the expiry cycle takes priority over the timeout
  assign timeout  = !rx_valid && (state != S_IDLE) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      key_held  <= '0;
      pulse     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_held  <= held_nxt;
      pulse     <= pulse_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (err_byte || timeout) begin
      state_nxt = S_IDLE;
    end else if (byte_ok) begin
      case (state)
        S_IDLE: begin
          if (is_ext)      state_nxt = S_EXT;
          else if (is_brk) state_nxt = S_BRK;
        end
        S_BRK: begin
          if (is_ext)       state_nxt = S_EXT_BRK;
          else if (!is_brk) state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (is_brk)       state_nxt = S_EXT_BRK;
          else if (!is_ext) state_nxt = S_IDLE;
        end
        S_EXT_BRK: begin
          if (!is_brk && !is_ext) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    if (rx_valid || timeout || (state == S_IDLE)) cnt_nxt = '0;
    else                                          cnt_nxt = cnt + 1'b1;
  end

  always_comb begin
    pulse_nxt = '0;
    held_nxt  = key_held;
    ferr_nxt  = err_byte || timeout;
    if (err_byte) begin
      held_nxt = '0;
    end else if (byte_ok && (state == S_IDLE)) begin
      // Typematic repeats of a held key are swallowed
      if ((key_hit & key_held) == 5'd0) pulse_nxt = key_hit;
      held_nxt = key_held | key_hit;
    end else if (byte_ok && (state == S_BRK)) begin
      held_nxt = key_held & ~key_hit;
    end
  end

  assign help        = pulse[0];
  assign menu        = pulse[1];
  assign select_map  = pulse[2];
  assign game_forest = pulse[3];
  assign game_castle = pulse[4];

endmodule

`default_nettype wire
